// File: rtl/pipe_skid_reg_if.sv
// pipe_skid_reg_if: valid/ready/data handshake between pipeline stages.
interface pipe_skid_reg_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    modport master (output valid, output data, input ready);
    modport slave (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid register stage with registered in_ready and flush.
module pipe_skid_reg #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] FLUSH_DATA = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    pipe_skid_reg_if.slave         s_in,
    pipe_skid_reg_if.master        m_out,
    output logic [1:0]             o_occupancy,
    output logic                   o_flush_drop
);
    typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;
    state_t           r_state;
    logic             r_main_v;
    logic             r_skid_v;
    logic             r_in_ready;
    logic [1:0]       r_occ;
    logic             r_drop;
    logic [WIDTH-1:0] r_main_d;
    logic [WIDTH-1:0] r_skid_d;
    logic             w_acc;
    logic             w_con;
    assign w_acc        = s_in.valid & r_in_ready;
    assign w_con        = r_main_v & m_out.ready;
    assign s_in.ready   = r_in_ready;
    assign m_out.valid  = r_main_v;
    assign m_out.data   = r_main_d;
    assign o_occupancy  = r_occ;
    assign o_flush_drop = r_drop;
    // in_ready, occupancy and the valid bits are registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_main_v   <= 1'b0;
            r_skid_v   <= 1'b0;
            r_in_ready <= 1'b1;
            r_occ      <= 2'd0;
            r_drop     <= 1'b0;
            r_main_d   <= FLUSH_DATA;
            r_skid_d   <= FLUSH_DATA;
        end else begin
            r_drop <= i_flush & (r_main_v | r_skid_v | w_acc);
            if (i_flush) begin
                r_state    <= EMPTY;
                r_main_v   <= 1'b0;
                r_skid_v   <= 1'b0;
                r_in_ready <= 1'b1;
                r_occ      <= 2'd0;
                r_main_d   <= FLUSH_DATA;
                r_skid_d   <= FLUSH_DATA;
            end else begin
                case (r_state)
                    EMPTY: if (w_acc) begin
                        r_main_d <= s_in.data;
                        r_main_v <= 1'b1;
                        r_occ    <= 2'd1;
                        r_state  <= HALF;
                    end
                    HALF: if (w_acc && w_con) begin
                        r_main_d <= s_in.data;
                    end else if (w_acc) begin
                        r_skid_d   <= s_in.data;
                        r_skid_v   <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_occ      <= 2'd2;
                        r_state    <= FULL;
                    end else if (w_con) begin
                        r_main_v <= 1'b0;
                        r_occ    <= 2'd0;
                        r_state  <= EMPTY;
                    end
                    FULL: if (w_con) begin
                        r_main_d   <= r_skid_d;
                        r_skid_v   <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_occ      <= 2'd1;
                        r_state    <= HALF;
                    end
                    default: begin
                        r_state    <= EMPTY;
                        r_main_v   <= 1'b0;
                        r_skid_v   <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_occ      <= 2'd0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed and random checks of pipe_skid_reg at WIDTH=8 and WIDTH=64 against a queue model.
module tb_pipe_skid_reg;
    localparam logic [7:0]  FD8  = 8'h5A;
    localparam logic [63:0] FD64 = 64'h0123_4567_89AB_CDEF;
    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic [1:0] occ8, occ64;
    logic       drop8, drop64;
    int         checks = 0;
    int         failures = 0;
    pipe_skid_reg_if #(.WIDTH(8))  up8 ();
    pipe_skid_reg_if #(.WIDTH(8))  dn8 ();
    pipe_skid_reg_if #(.WIDTH(64)) up64 ();
    pipe_skid_reg_if #(.WIDTH(64)) dn64 ();
    assign up8.valid  = in_valid;
    assign up8.data   = in_data;
    assign dn8.ready  = out_ready;
    assign up64.valid = in_valid;
    assign up64.data  = {8{in_data}};
    assign dn64.ready = out_ready;
    pipe_skid_reg #(.WIDTH(8), .FLUSH_DATA(FD8)) dut8 (
        .clk(clk), .rst(rst), .i_flush(flush), .s_in(up8), .m_out(dn8),
        .o_occupancy(occ8), .o_flush_drop(drop8)
    );
    pipe_skid_reg #(.WIDTH(64), .FLUSH_DATA(FD64)) dut64 (
        .clk(clk), .rst(rst), .i_flush(flush), .s_in(up64), .m_out(dn64),
        .o_occupancy(occ64), .o_flush_drop(drop64)
    );
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the stage is a FIFO of depth 2; ready means "fewer than two words held".
    logic [7:0] q[$];
    bit         m_flushed = 1'b1;
    bit         m_drop = 1'b0;
    always @(posedge clk or posedge rst) begin
        automatic bit acc, con;
        if (rst) begin
            q.delete();
            m_flushed = 1'b1;
            m_drop = 1'b0;
        end else begin
            acc = in_valid && q.size() < 2;
            con = q.size() > 0 && out_ready;
            if (flush) begin
                m_drop = q.size() > 0 || acc;
                q.delete();
                m_flushed = 1'b1;
            end else begin
                m_drop = 1'b0;
                if (con) void'(q.pop_front());
                if (acc) begin
                    q.push_back(in_data);
                    m_flushed = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("valid8", dn8.valid, q.size() > 0);
            chk("ready8", up8.ready, q.size() < 2);
            chk("occ8", occ8, q.size());
            chk("drop8", drop8, m_drop);
            chk("valid64", dn64.valid, q.size() > 0);
            chk("ready64", up64.ready, q.size() < 2);
            chk("occ64", occ64, q.size());
            chk("drop64", drop64, m_drop);
            if (q.size() > 0) begin
                chk("data8", dn8.data, q[0]);
                chk("data64", dn64.data, {8{q[0]}});
            end else if (m_flushed) begin
                chk("fdata8", dn8.data, FD8);
                chk("fdata64", dn64.data, FD64);
            end
        end
    end

    task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic rdy;
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", dn8.valid, 1'b0);
        chk("rst_ready", up8.ready, 1'b1);
        chk("rst_occ", occ8, 2'd0);
        chk("rst_drop", drop8, 1'b0);
        chk("rst_data8", dn8.data, 8'h5A);
        chk("rst_data64", dn64.data, 64'h0123_4567_89AB_CDEF);
        rst = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            cyc(1'b1, 8'(i), 1'b1, 1'b0);
            if (i == 1) begin
                chk("stream_first", dn8.data, 8'd1);
                chk("stream_occ", occ8, 2'd1);
            end
        end
        chk("stream_last", dn8.data, 8'd100);
        chk("stream_last_occ", occ8, 2'd1);
        cyc(1'b0, 8'h0, 1'b1, 1'b0);
        chk("stream_drain", occ8, 2'd0);
        cyc(1'b1, 8'h0A, 1'b0, 1'b0);
        cyc(1'b1, 8'h0B, 1'b0, 1'b0);
        chk("stall_occ", occ8, 2'd2);
        chk("stall_ready", up8.ready, 1'b0);
        chk("stall_data", dn8.data, 8'h0A);
        cyc(1'b0, 8'h0, 1'b0, 1'b0);
        chk("stall_stable", dn8.data, 8'h0A);
        rdy = up8.ready;
        out_ready = 1'b1;
        #1;
        chk("no_comb_path", up8.ready, rdy);
        cyc(1'b0, 8'h0, 1'b1, 1'b0);
        chk("unstall_data", dn8.data, 8'h0B);
        chk("unstall_ready", up8.ready, 1'b1);
        cyc(1'b0, 8'h0, 1'b1, 1'b0);
        chk("unstall_empty", dn8.valid, 1'b0);
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        cyc(1'b1, 8'h33, 1'b1, 1'b1);
        chk("fl_occ", occ8, 2'd0);
        chk("fl_valid", dn8.valid, 1'b0);
        chk("fl_drop", drop8, 1'b1);
        chk("fl_data", dn8.data, 8'h5A);
        cyc(1'b0, 8'h0, 1'b1, 1'b0);
        chk("fl_drop_pulse", drop8, 1'b0);
        cyc(1'b0, 8'h0, 1'b0, 1'b1);
        chk("empty_flush_drop", drop8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'h44, 1'b1, 1'b1);
            chk("flush_hold_ready", up8.ready, 1'b1);
            chk("flush_hold_occ", occ8, 2'd0);
        end
        cyc(1'b1, 8'h01, 1'b0, 1'b0);
        cyc(1'b1, 8'h02, 1'b0, 1'b0);
        chk("pre_areset_occ", occ8, 2'd2);
        #2 rst = 1'b1;
        #1;
        chk("areset_valid", dn8.valid, 1'b0);
        chk("areset_ready", up8.ready, 1'b1);
        chk("areset_occ", occ8, 2'd0);
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1'b1, 8'h77, 1'b0, 1'b0);
        chk("post_reset_load", dn8.data, 8'h77);
        for (int i = 0; i < 10000; i++)
            cyc(1'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 99) == 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
